// File: rtl/bus_pkg.sv
// Shared bus constants, widths and the bridge state encoding.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 8;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } bridge_state_t;

endpackage

// File: rtl/bus_txn_timer.sv
// Clear/enable transaction timer; flags when the count reaches LIMIT-1.
module bus_txn_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count;

  // Count enabled cycles since the last clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command stream to 16-bit-address bus master with timeout and byte response.
module uart_bus_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [7:0]  OP_WRITE    = bus_pkg::OP_WRITE,
  parameter logic [7:0]  OP_READ     = bus_pkg::OP_READ,
  parameter logic [7:0]  RSP_ACK     = bus_pkg::RSP_ACK,
  parameter logic [7:0]  RSP_ERR     = bus_pkg::RSP_ERR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [bus_pkg::BUS_ADDR_W-1:0] Addr,
  output logic [bus_pkg::BUS_DATA_W-1:0] WData,
  output logic                          RW,
  output logic                          Cmd,
  input  logic [bus_pkg::BUS_DATA_W-1:0] RData,
  input  logic                          Finish
);

  import bus_pkg::*;

  bridge_state_t state_q, state_d;
  logic          tmr_expired;

  bus_txn_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == ST_ISSUE),
    .en      (state_q == ST_WAIT),
    .expired (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe outputs; Cmd lives only in the single ISSUE cycle.
  always_comb begin
    state_d  = state_q;
    Cmd      = 1'b0;
    tx_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
          state_d = ST_ADDR_H;
        end
      end
      ST_ADDR_H: begin
        if (rx_valid) state_d = ST_ADDR_L;
      end
      ST_ADDR_L: begin
        if (rx_valid) state_d = RW ? ST_DATA : ST_ISSUE;
      end
      ST_DATA: begin
        if (rx_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        Cmd     = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (Finish || tmr_expired) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command fields and response byte; Finish takes priority over timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RW      <= 1'b0;
      Addr    <= '0;
      WData   <= '0;
      tx_data <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_data == OP_WRITE) begin
            RW <= 1'b1;
          end else if (rx_valid && rx_data == OP_READ) begin
            RW <= 1'b0;
          end
        end
        ST_ADDR_H: begin
          if (rx_valid) Addr[15:8] <= rx_data;
        end
        ST_ADDR_L: begin
          if (rx_valid) Addr[7:0] <= rx_data;
        end
        ST_DATA: begin
          if (rx_valid) WData <= rx_data;
        end
        ST_WAIT: begin
          if (Finish) begin
            tx_data <= RW ? RSP_ACK : RData;
          end else if (tmr_expired) begin
            tx_data <= RSP_ERR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed + randomized bench for uart_bus_bridge with a transaction-level reference model.
module tb_uart_bus_bridge;

  localparam int T = 255;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [15:0] Addr;
  logic [7:0]  WData;
  logic        RW;
  logic        Cmd;
  logic [7:0]  RData;
  logic        Finish;

  int checks = 0;
  int errors = 0;
  int cmd_count = 0;
  int start_count = 0;
  int consec = 0;
  logic prev_cmd = 1'b0;

  logic [7:0] mem [logic [15:0]];

  uart_bus_bridge #(
    .TIMEOUT_CYC (T)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .Addr     (Addr),
    .WData    (WData),
    .RW       (RW),
    .Cmd      (Cmd),
    .RData    (RData),
    .Finish   (Finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (Cmd) cmd_count <= cmd_count + 1;
    if (tx_start) start_count <= start_count + 1;
    if (Cmd && prev_cmd) consec <= consec + 1;
    prev_cmd <= Cmd;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // fin_at: cycles after the Cmd cycle at which Finish pulses (-1 = never).
  // busy_until: tx_busy held high for cycles k < busy_until (k=0 is the Cmd cycle).
  // drop_at: cycle at which a stray rx byte arrives (-1 = none).
  task automatic run_txn(input logic [7:0] op, input logic [15:0] a, input logic [7:0] wd,
                         input int fin_at, input logic [7:0] rd, input int busy_until,
                         input int drop_at);
    int         c0;
    int         ready;
    int         exp_start;
    int         seen;
    bit         accepted;
    bit         is_wr;
    logic [7:0] exp_byte;
    logic [7:0] got_byte;
    c0    = cmd_count;
    is_wr = (op == 8'h57);
    send_byte(op);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    if (is_wr) send_byte(wd);

    check("cmd_issue", 16'(Cmd), 16'h1);
    check("cmd_addr", Addr, a);
    check("cmd_rw", 16'(RW), 16'(is_wr));
    if (is_wr) check("cmd_wdata", 16'(WData), 16'(wd));

    accepted  = (fin_at >= 1) && (fin_at <= T);
    ready     = accepted ? fin_at + 1 : T + 1;
    exp_start = (busy_until > ready) ? busy_until : ready;
    exp_byte  = !accepted ? 8'hEE : (is_wr ? 8'h4B : rd);
    if (accepted && is_wr) mem[a] = wd;

    seen     = -1;
    got_byte = 8'h00;
    for (int k = 0; k <= exp_start + 20; k++) begin
      Finish   = (k == fin_at);
      RData    = (k == fin_at) ? rd : 8'($urandom);
      tx_busy  = (k < busy_until);
      rx_valid = (k == drop_at);
      rx_data  = 8'h57;
      #1;
      if (tx_start) begin
        seen     = k;
        got_byte = tx_data;
        break;
      end
      if (tx_busy && k >= ready) check("rsp_hold", 16'(tx_data), 16'(exp_byte));
      tick();
    end
    Finish   = 1'b0;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;

    check("start_seen", 16'(seen >= 0), 16'h1);
    check("start_cyc", 16'(seen), 16'(exp_start));
    check("rsp_byte", 16'(got_byte), 16'(exp_byte));
    tick();
    check("start_pulse", 16'(tx_start), 16'h0);
    check("cmd_once", 16'(cmd_count - c0), 16'h1);
    check("cmd_consec", 16'(consec), 16'h0);
  endtask

  initial begin
    logic [7:0]  op;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  rd;
    int          c0;
    int          s0;

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    RData    = 8'h00;
    Finish   = 1'b0;
    tick();
    tick();
    check("rst_cmd", 16'(Cmd), 16'h0);
    check("rst_start", 16'(tx_start), 16'h0);
    check("rst_rw", 16'(RW), 16'h0);
    check("rst_addr", Addr, 16'h0000);
    check("rst_wdata", 16'(WData), 16'h0);
    check("rst_txdata", 16'(tx_data), 16'h0);
    rst_n = 1'b1;
    tick();

    // Basic write then read-back.
    run_txn(8'h57, 16'h0005, 8'hA5, 1, 8'h00, 0, -1);
    run_txn(8'h52, 16'h0005, 8'h00, 2, mem[16'h0005], 0, -1);

    // Garbage opcode dropped, then a write completes.
    c0 = cmd_count;
    send_byte(8'h13);
    tick();
    check("garbage_nocmd", 16'(cmd_count - c0), 16'h0);
    run_txn(8'h57, 16'h000F, 8'h3C, 1, 8'h00, 0, -1);

    // Timeout, then a late Finish in IDLE must be ignored.
    run_txn(8'h52, 16'h1000, 8'h00, -1, 8'h00, 0, -1);
    c0 = cmd_count;
    s0 = start_count;
    repeat (9) tick();
    Finish = 1'b1;
    RData  = 8'h77;
    tick();
    Finish = 1'b0;
    repeat (20) tick();
    check("late_fin_start", 16'(start_count - s0), 16'h0);
    check("late_fin_cmd", 16'(cmd_count - c0), 16'h0);

    // Back-pressure for 50 cycles at RESP with a stray rx byte during WAIT.
    run_txn(8'h52, 16'h000F, 8'h00, 3, mem[16'h000F], 4 + 50, 2);
    run_txn(8'h57, 16'h0042, 8'h99, 2, 8'h00, 3 + 50, 1);

    // Finish on the last allowed cycle wins; one cycle later is a timeout.
    run_txn(8'h52, 16'hBEEF, 8'h00, T, 8'h5A, 0, -1);
    run_txn(8'h57, 16'hBEF0, 8'h11, T + 1, 8'h00, 0, -1);

    // Reset after the low address byte of a write abandons it.
    c0 = cmd_count;
    s0 = start_count;
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h05);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_cmd", 16'(Cmd), 16'h0);
    check("midrst_addr", Addr, 16'h0000);
    check("midrst_rw", 16'(RW), 16'h0);
    repeat (10) tick();
    check("midrst_nocmd", 16'(cmd_count - c0), 16'h0);
    check("midrst_nostart", 16'(start_count - s0), 16'h0);
    run_txn(8'h52, 16'h0042, 8'h00, 1, mem[16'h0042], 0, -1);

    // Randomized transactions against the slave memory model.
    for (int n = 0; n < 10; n++) begin
      op = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
      a  = {8'h20, 6'h00, 2'($urandom)};
      d  = 8'($urandom);
      rd = mem.exists(a) ? mem[a] : 8'($urandom);
      run_txn(op, a, d, int'($urandom_range(1, 8)), rd, int'($urandom_range(0, 6)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Upstream bus master for the small-RAM bus slaves; sits between the UART byte receiver/transmitter and the 16-bit-address bus.
- Parses a byte-serial command stream (opcode, address high, address low, optional data).
- Issues one bus transaction per command and waits for Finish.
- Returns an ACK, the read byte, or an error byte over UART TX.

Parameters:
- TIMEOUT_CYC, 255: max cycles from the Cmd pulse to Finish before abort. Range 1..65535.
- OP_WRITE, 8'h57: write opcode ('W').
- OP_READ, 8'h52: read opcode ('R').
- RSP_ACK, 8'h4B: byte sent after a successful write.
- RSP_ERR, 8'hEE: byte sent on bus timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- Addr  out  16  bus address
- WData  out  8  bus write data
- RW  out  1  1 = write, 0 = read
- Cmd  out  1  one-cycle transaction request
- RData  in  8  bus read data
- Finish  in  1  one-cycle completion strobe from slave

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset: Cmd=0, tx_start=0, RW=0, Addr=0, WData=0, tx_data=0, timeout counter=0, state=IDLE. Reset mid-command abandons the command with no response and no further Cmd.
- States: IDLE, ADDR_H, ADDR_L, DATA, ISSUE, WAIT, RESP.
- IDLE, on rx_valid:
  - rx_data==OP_WRITE: latch RW=1, go to ADDR_H.
  - rx_data==OP_READ: latch RW=0, go to ADDR_H.
  - Any other byte: silently dropped, stay in IDLE.
- ADDR_H, on rx_valid: Addr[15:8]<=rx_data, go to ADDR_L.
- ADDR_L, on rx_valid: Addr[7:0]<=rx_data. Go to DATA if RW=1, else ISSUE.
- DATA, on rx_valid: WData<=rx_data, go to ISSUE.
- ISSUE: Cmd=1 for exactly one cycle, clear the timeout counter, go to WAIT.
  - Cmd is never asserted on consecutive cycles; the slave would re-execute a held Cmd.
- WAIT:
  - Addr, WData and RW stay stable until Finish.
  - Counter increments each cycle.
  - Finish=1: capture RData in the same cycle. tx_data<=RData for a read, RSP_ACK for a write. Go to RESP.
  - Counter reaches TIMEOUT_CYC-1 without Finish: tx_data<=RSP_ERR, go to RESP.
  - Finish and timeout in the same cycle: Finish wins.
- RESP: when tx_busy==0, pulse tx_start for one cycle, then go to IDLE. While tx_busy==1, hold tx_data and wait; no timeout applies.
- rx_valid in ISSUE, WAIT or RESP: byte dropped. No queueing, no state change.
- Late Finish arriving in IDLE after a timeout: ignored.
- Latency: ISSUE follows the last command byte by 1 cycle. tx_start follows Finish by 1 cycle when tx_busy=0.
- Timeout counter is 16 bits wide; no wrap is possible within the parameter range.

Decomposition:
- Shared package bus_pkg:
  - opcode and response constants (OP_WRITE, OP_READ, RSP_ACK, RSP_ERR);
  - state encoding for this block;
  - bus address width (16) and data width (8).
- One natural sub-module: bus_txn_timer. It is the clear/enable counter with a timeout flag, reusable by other bus masters.
- Command parser, bus FSM and response logic stay in the top module.

Test Plan:
- Write: bytes 57,00,05,A5 -> one Cmd pulse with Addr=0005, RW=1, WData=A5. Slave asserts Finish 1 cycle later -> tx_start with tx_data=4B one cycle after Finish.
- Read-back: bytes 52,00,05 with the slave returning A5 -> Cmd with RW=0, Addr=0005 -> tx_data=A5, tx_start pulse. Cmd is high for exactly 1 cycle.
- Garbage opcode: bytes 13,57,00,0F,3C -> 13 is dropped; write to 000F with data 3C completes and 4B is sent.
- Timeout: bytes 52,10,00 with no slave responding -> after 255 cycles tx_data=EE, tx_start pulse. A Finish injected 10 cycles later causes no response.
- TX back-pressure and dropped RX: tx_busy held 1 for 50 cycles at RESP, plus an rx_valid during WAIT -> tx_start only after tx_busy falls, response byte unchanged, extra byte ignored.
- Reset mid-command: rst_n low after the ADDR_L byte of a write -> no Cmd issued. A subsequent full read command works normally.
